// File: rtl/motor_drive_sequencer.sv
// Per-wheel motor drive sequencer: arbitrates autonomous/RC commands, generates
// PWM and L298N direction pins, inserts coast dead time on reversal, stops on estop/watchdog.
module motor_drive_sequencer #(
    parameter int PWM_BITS     = 7,
    parameter int MIN_DUTY     = 5,
    parameter int DEAD_PERIODS = 4,
    parameter int WDOG_PERIODS = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                auto_valid,
    output logic                auto_ready,
    input  logic [PWM_BITS-1:0] auto_duty,
    input  logic                auto_dir,
    input  logic                rc_valid,
    output logic                rc_ready,
    input  logic [PWM_BITS-1:0] rc_duty,
    input  logic                rc_dir,
    input  logic                rc_override,
    input  logic                estop,
    output logic                pwm,
    output logic                in1_l298n_dir,
    output logic                in2_l298n_dir,
    output logic [PWM_BITS-1:0] active_duty,
    output logic                active_dir,
    output logic [1:0]          state,
    output logic                wdog_trip
);
    localparam int                  WD_W   = $clog2(WDOG_PERIODS + 1);
    localparam logic [PWM_BITS-1:0] MIN_D  = PWM_BITS'(MIN_DUTY);
    localparam logic [3:0]          DEAD_N = 4'(DEAD_PERIODS);
    localparam logic [WD_W-1:0]     WD_LIM = WD_W'(WDOG_PERIODS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_DRIVE = 2'b01,
        S_DEAD  = 2'b10,
        S_ESTOP = 2'b11
    } state_e;

    state_e              state_q, state_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic                pend_vld_q, pend_vld_d;
    logic [PWM_BITS-1:0] pend_duty_q, pend_duty_d;
    logic                pend_dir_q, pend_dir_d;
    logic [PWM_BITS-1:0] stg_duty_q, stg_duty_d;
    logic                stg_dir_q, stg_dir_d;
    logic [3:0]          dead_q, dead_d;
    logic [WD_W-1:0]     wdog_q, wdog_d;
    logic [PWM_BITS-1:0] act_duty_q, act_duty_d;
    logic                act_dir_q, act_dir_d;
    logic                trip_q, trip_d;

    logic                period_end, win_valid, win_dir, win_ready, accept, pend_zero, wdog_hit;
    logic [PWM_BITS-1:0] win_duty;

    assign period_end = (cnt_q == '1);
    assign win_valid  = rc_override ? rc_valid : auto_valid;
    assign win_duty   = rc_override ? rc_duty  : auto_duty;
    assign win_dir    = rc_override ? rc_dir   : auto_dir;
    assign win_ready  = !pend_vld_q && (state_q != S_ESTOP);
    assign accept     = win_valid && win_ready;
    assign pend_zero  = (pend_duty_q < MIN_D);
    // An acceptance in the same cycle as the period end counts as a fresh command.
    assign wdog_hit   = ((state_q == S_DRIVE) || (state_q == S_DEAD)) && period_end &&
                        !accept && (wdog_q == WD_LIM - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pend_vld_q  <= 1'b0;
            pend_duty_q <= '0;
            pend_dir_q  <= 1'b0;
            stg_duty_q  <= '0;
            stg_dir_q   <= 1'b0;
            dead_q      <= '0;
            wdog_q      <= '0;
            act_duty_q  <= '0;
            act_dir_q   <= 1'b0;
            trip_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_vld_q  <= pend_vld_d;
            pend_duty_q <= pend_duty_d;
            pend_dir_q  <= pend_dir_d;
            stg_duty_q  <= stg_duty_d;
            stg_dir_q   <= stg_dir_d;
            dead_q      <= dead_d;
            wdog_q      <= wdog_d;
            act_duty_q  <= act_duty_d;
            act_dir_q   <= act_dir_d;
            trip_q      <= trip_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        pend_vld_d  = pend_vld_q;
        pend_duty_d = pend_duty_q;
        pend_dir_d  = pend_dir_q;
        stg_duty_d  = stg_duty_q;
        stg_dir_d   = stg_dir_q;
        dead_d      = dead_q;
        wdog_d      = wdog_q;
        act_duty_d  = act_duty_q;
        act_dir_d   = act_dir_q;
        trip_d      = 1'b0;

        if (estop) begin
            state_d    = S_ESTOP;
            pend_vld_d = 1'b0;
            stg_duty_d = '0;
            stg_dir_d  = 1'b0;
            dead_d     = '0;
            wdog_d     = '0;
            act_duty_d = '0;
        end else if (state_q == S_ESTOP) begin
            wdog_d = '0;
            if (period_end) state_d = S_IDLE;
        end else begin
            if (accept) begin
                pend_vld_d  = 1'b1;
                pend_duty_d = win_duty;
                pend_dir_d  = win_dir;
            end
            if ((state_q == S_IDLE) || accept) wdog_d = '0;
            else if (period_end && (wdog_q != WD_LIM)) wdog_d = wdog_q + 1'b1;

            if (wdog_hit) begin
                state_d    = S_IDLE;
                pend_vld_d = 1'b0;
                stg_duty_d = '0;
                stg_dir_d  = 1'b0;
                dead_d     = '0;
                wdog_d     = '0;
                act_duty_d = '0;
                trip_d     = 1'b1;
            end else if (period_end) begin
                case (state_q)
                    S_IDLE: if (pend_vld_q) begin
                        pend_vld_d = 1'b0;
                        if (!pend_zero) begin
                            state_d    = S_DRIVE;
                            act_duty_d = pend_duty_q;
                            act_dir_d  = pend_dir_q;
                        end
                    end
                    S_DRIVE: if (pend_vld_q) begin
                        pend_vld_d = 1'b0;
                        if (pend_zero) begin
                            state_d    = S_IDLE;
                            act_duty_d = '0;
                        end else if (pend_dir_q == act_dir_q) begin
                            act_duty_d = pend_duty_q;
                        end else begin
                            state_d    = S_DEAD;
                            stg_duty_d = pend_duty_q;
                            stg_dir_d  = pend_dir_q;
                            dead_d     = DEAD_N;
                            act_duty_d = '0;
                        end
                    end
                    S_DEAD: begin
                        // Pending is left alone here; it is consumed once back in DRIVE.
                        if (dead_q == 4'd1) begin
                            state_d    = S_DRIVE;
                            act_duty_d = stg_duty_q;
                            act_dir_d  = stg_dir_q;
                            stg_duty_d = '0;
                            stg_dir_d  = 1'b0;
                            dead_d     = '0;
                        end else begin
                            dead_d = dead_q - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        pwm           = (state_q == S_DRIVE) && (cnt_q < act_duty_q);
        in1_l298n_dir = (state_q == S_DRIVE) && !act_dir_q;
        in2_l298n_dir = (state_q == S_DRIVE) && act_dir_q;
        active_duty   = (state_q == S_DRIVE) ? act_duty_q : '0;
        active_dir    = act_dir_q;
        state         = state_q;
        wdog_trip     = trip_q;
        // The losing source is always ready so its commands drain and are dropped.
        auto_ready    = (state_q == S_ESTOP) || rc_override || !pend_vld_q;
        rc_ready      = (state_q == S_ESTOP) || !rc_override || !pend_vld_q;
    end
endmodule

// File: tb/tb_motor_drive_sequencer.sv
// Scoreboard bench: stimulus queues expected outputs keyed by cycle since reset;
// a monitor compares them against the DUT on the falling edge.
module tb_motor_drive_sequencer;
    localparam int X = -1;

    logic       clk, rst_n;
    logic       auto_valid, auto_ready, auto_dir;
    logic [6:0] auto_duty;
    logic       rc_valid, rc_ready, rc_dir, rc_override, estop;
    logic [6:0] rc_duty;
    logic       pwm, in1, in2, active_dir, wdog_trip;
    logic [6:0] active_duty;
    logic [1:0] state;

    motor_drive_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .auto_valid(auto_valid), .auto_ready(auto_ready), .auto_duty(auto_duty), .auto_dir(auto_dir),
        .rc_valid(rc_valid), .rc_ready(rc_ready), .rc_duty(rc_duty), .rc_dir(rc_dir),
        .rc_override(rc_override), .estop(estop),
        .pwm(pwm), .in1_l298n_dir(in1), .in2_l298n_dir(in2),
        .active_duty(active_duty), .active_dir(active_dir), .state(state), .wdog_trip(wdog_trip)
    );

    typedef struct {
        int    cyc;
        string nm;
        int    st, pins, duty, pw, hi, trip, ardy, rrdy;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_bad = 0;
    int   cyc;
    int   hic;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    function automatic void ex(int c, string nm, int st, int pins, int duty, int pw,
                               int hi, int trip, int ardy, int rrdy);
        exp_t e;
        e.cyc = c; e.nm = nm; e.st = st; e.pins = pins; e.duty = duty; e.pw = pw;
        e.hi = hi; e.trip = trip; e.ardy = ardy; e.rrdy = rrdy;
        q.push_back(e);
    endfunction

    task automatic cmp(string nm, string fld, int act, int expv);
        if (expv >= 0) begin
            n_cmp++;
            if (act != expv) begin
                n_bad++;
                $display("FAIL %s.%s at cyc %0d: got %0d, want %0d", nm, fld, cyc, act, expv);
            end
        end
    endtask

    // Monitor: accumulate pwm high ticks per period and check due expectations.
    initial begin
        exp_t e;
        hic = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (cyc % 128 == 0) hic = int'(pwm);
                else                hic = hic + int'(pwm);
                while (q.size() > 0 && q[0].cyc <= cyc) begin
                    e = q.pop_front();
                    if (e.cyc < cyc) begin
                        n_cmp++; n_bad++;
                        $display("FAIL %s: check due at cyc %0d missed, now %0d", e.nm, e.cyc, cyc);
                    end else begin
                        cmp(e.nm, "state", int'(state), e.st);
                        cmp(e.nm, "pins", int'({in1, in2}), e.pins);
                        cmp(e.nm, "duty", int'(active_duty), e.duty);
                        cmp(e.nm, "pwm", int'(pwm), e.pw);
                        cmp(e.nm, "hi_ticks", hic, e.hi);
                        cmp(e.nm, "wdog_trip", int'(wdog_trip), e.trip);
                        cmp(e.nm, "auto_ready", int'(auto_ready), e.ardy);
                        cmp(e.nm, "rc_ready", int'(rc_ready), e.rrdy);
                    end
                end
            end
        end
    end

    task automatic wait_cyc(int n);
        while (cyc < n) @(negedge clk);
        #1;
    endtask

    task automatic send_auto(int duty, int dir);
        logic r;
        bit   ok;
        ok = 0;
        auto_duty = 7'(duty); auto_dir = dir[0]; auto_valid = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            r = auto_ready;
            @(negedge clk); #1;
            if (r) begin ok = 1; break; end
        end
        auto_valid = 1'b0;
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL send_auto: no handshake for duty %0d, ready stuck at %0d", duty, auto_ready);
        end
    endtask

    task automatic drain_queue();
        for (int i = 0; i < 3000 && q.size() > 0; i++) @(negedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; auto_valid = 1'b0; auto_duty = '0; auto_dir = 1'b0;
        rc_valid = 1'b0; rc_duty = '0; rc_dir = 1'b0; rc_override = 1'b0; estop = 1'b0;
        ex(0, "reset", 0, 0, 0, 0, X, 0, 1, 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic drive: 64 fwd accepted at cnt 10, effective from next period.
        ex(11,  "a_pend",   0, 0, 0, 0, X, X, 0, 1);
        ex(128, "a_drv",    1, 2, 64, 1, X, 0, 1, 1);
        ex(191, "a_hi_end", 1, 2, 64, 1, X, X, X, X);
        ex(192, "a_lo",     X, X, X, 0, X, X, X, X);
        ex(255, "a_per",    1, 2, 64, 0, 64, X, X, X);
        // Reversal to rev 80 with dead time; a DEAD-time command, then a back-pressured one.
        ex(383,  "b_last_fwd", 1, 2, 64, 0, 64, X, X, X);
        ex(384,  "b_dead",     2, 0, 0, 0, X, X, 1, X);
        ex(401,  "b_dead_pend",2, 0, 0, 0, X, X, 0, 1);
        ex(511,  "b_dead_p1",  2, 0, 0, 0, 0, X, X, X);
        ex(700,  "b_hold",     2, 0, 0, 0, X, X, 0, X);
        ex(895,  "b_dead_p4",  2, 0, 0, 0, 0, X, 0, X);
        ex(896,  "b_rev",      1, 1, 80, 1, X, X, 0, X);
        ex(1023, "b_rev_per",  1, 1, 80, 0, 80, X, 0, X);
        ex(1024, "b_rel",      1, 1, 90, 1, X, X, 1, X);
        ex(1151, "b_90",       1, 1, 90, 0, 90, X, X, X);
        ex(1152, "b_70",       1, 1, 70, 1, X, X, X, X);

        wait_cyc(10);  send_auto(64, 0);
        wait_cyc(260); send_auto(80, 1);
        wait_cyc(400); send_auto(90, 1);
        wait_cyc(500); send_auto(70, 1);

        // Sub-minimum duty stops; RC override wins and auto is discarded.
        ex(1279, "c_last",     1, 1, 70, 0, 70, X, X, X);
        ex(1280, "c_idle",     0, 0, 0, 0, X, X, X, X);
        ex(1301, "d_acc",      0, 0, 0, 0, X, X, 1, 0);
        ex(1302, "d_blk",      0, 0, 0, 0, X, X, 0, 1);
        ex(1407, "c_idle_per", 0, 0, 0, 0, 0, X, X, X);
        ex(1408, "d_rc",       1, 2, 40, 1, X, X, X, X);
        ex(1535, "d_per",      1, 2, 40, 0, 40, X, X, X);
        // Estop mid-period, commands discarded, exit at period end.
        ex(1566, "e_pre",  1, 2, 40, 1, X, X, X, X);
        ex(1567, "e_stop", 3, 0, 0, 0, X, X, 1, 1);
        ex(1601, "e_disc", 3, 0, 0, 0, X, X, 1, 1);
        ex(1663, "e_hold", 3, 0, 0, 0, X, X, X, X);
        ex(1664, "e_idle", 0, 0, 0, 0, X, X, 1, 1);
        ex(1791, "e_none", 0, 0, 0, 0, 0, X, X, X);

        wait_cyc(1160); send_auto(3, 1);
        wait_cyc(1300);
        rc_override = 1'b1;
        auto_valid = 1'b1; auto_duty = 7'd100; auto_dir = 1'b0;
        rc_valid = 1'b1;   rc_duty = 7'd40;    rc_dir = 1'b0;
        wait_cyc(1301);
        auto_valid = 1'b0; rc_valid = 1'b0; rc_override = 1'b0;
        wait_cyc(1566); estop = 1'b1;
        wait_cyc(1567); estop = 1'b0;
        wait_cyc(1600); send_auto(60, 0);

        // Watchdog: restart by a command in period 30, trip after 64 more period ends.
        ex(1920,  "f_drv",     1, 2, 50, 1, X, 0, X, X);
        ex(2047,  "f_per",     1, 2, 50, 0, 50, 0, X, X);
        ex(10112, "f_restart", 1, 2, 50, 1, X, 0, X, X);
        ex(12031, "f_last",    1, 2, 50, 0, 50, 0, X, X);
        ex(12032, "f_trip",    0, 0, 0, 0, X, 1, 1, 1);
        ex(12033, "f_pulse",   0, 0, 0, 0, X, 0, X, X);
        ex(12160, "g_drv",     1, 2, 60, 1, X, 0, X, X);
        ex(12300, "g_dead",    2, 0, 0, 0, X, X, X, X);

        wait_cyc(1800);  send_auto(50, 0);
        wait_cyc(3845);  send_auto(50, 0);
        wait_cyc(12040); send_auto(60, 0);
        wait_cyc(12170); send_auto(60, 1);

        // Asynchronous reset pulse mid-DEAD, entirely between clock edges.
        wait_cyc(12350);
        drain_queue();
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        ex(1,   "g_rst",      0, 0, 0, 0, X, 0, 1, 1);
        ex(128, "g_idle",     0, 0, 0, 0, X, X, X, X);
        ex(767, "g_noresume", 0, 0, 0, 0, 0, 0, 1, 1);
        drain_queue();

        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
